ram82s21_ctl: RTL and testbench

RAM82S21_CTL -- requirements
Module: ram82s21_ctl

---
 rtl/ram82s21_pkg.sv | 16 +
 rtl/ram82s21_pulse_cnt.sv | 33 +++
 rtl/ram82s21_ctl.sv | 157 +++++++++++++++
 tb/tb_ram82s21_ctl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram82s21_pkg.sv
// Shared definitions for the 82S21 RAM controller: FSM states and array geometry.
package ram82s21_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    READ,
    RESP
  } state_t;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

endpackage

// File: rtl/ram82s21_pulse_cnt.sv
// Write-pulse length counter: loaded in SETUP, counts down through PULSE, done at zero.
module ram82s21_pulse_cnt #(
  parameter int unsigned WR_PULSE = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 3'(WR_PULSE - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ram82s21_ctl.sv
// Request/response controller for a 32x2 82S21 RAM with write pulse timing and zero fill.
module ram82s21_ctl
  import ram82s21_pkg::*;
#(
  parameter int unsigned WR_PULSE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_wdata,
  input  logic [1:0]    req_bmask,
  output logic          rsp_valid,
  output logic [1:0]    rsp_rdata,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic [AW-1:0] ram_a,
  output logic [1:0]    ram_i,
  output logic          ram_we0_n,
  output logic          ram_we1_n,
  output logic          ram_latch_n,
  output logic          ram_wclk_n,
  output logic          ram_ce,
  input  logic [1:0]    ram_d
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]    wdata_q, wdata_d;
  logic [1:0]    bmask_q, bmask_d;
  logic [1:0]    rdata_q, rdata_d;
  logic          clr_busy_q, clr_busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          latch_n_q, latch_n_d;
  logic          wclk_n_q, wclk_n_d;
  logic          we0_n_q, we0_n_d;
  logic          we1_n_q, we1_n_d;
  logic          ce_q, ce_d;
  logic          pulse_load, pulse_done;

  ram82s21_pulse_cnt #(.WR_PULSE(WR_PULSE)) u_pulse_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (pulse_load),
    .en_i    (state_q == PULSE),
    .done_o  (pulse_done)
  );

  // clear_start masks req_ready so a simultaneous request is never accepted.
  assign req_ready = (state_q == IDLE) && !clr_busy_q && !clear_start && !reset;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    clr_cnt_d  = clr_cnt_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    rdata_d    = rdata_q;
    clr_busy_d = clr_busy_q;
    pulse_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start && !clr_busy_q) begin
          clr_busy_d = 1'b1;
          clr_cnt_d  = '0;
          addr_d     = '0;
          wdata_d    = '0;
          bmask_d    = '1;
          state_d    = SETUP;
        end else if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bmask_d = req_bmask;
          state_d = req_write ? SETUP : READ;
        end
      end
      SETUP: begin
        pulse_load = 1'b1;
        state_d    = PULSE;
      end
      PULSE: begin
        if (pulse_done) state_d = HOLD;
      end
      HOLD: begin
        if (clr_busy_q && (clr_cnt_q != AW'(DEPTH - 1))) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          addr_d    = clr_cnt_d;
          state_d   = SETUP;
        end else begin
          clr_busy_d = 1'b0;
          state_d    = IDLE;
        end
      end
      READ: begin
        rdata_d = ram_d;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RAM pins are decoded from the next state so they are registered yet aligned with it.
    latch_n_d   = (state_d != PULSE);
    wclk_n_d    = (state_d != PULSE);
    we0_n_d     = !((state_d == PULSE) && bmask_d[0]);
    we1_n_d     = !((state_d == PULSE) && bmask_d[1]);
    ce_d        = (state_d == READ);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      clr_cnt_q   <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rdata_q     <= '0;
      clr_busy_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      latch_n_q   <= 1'b1;
      wclk_n_q    <= 1'b1;
      we0_n_q     <= 1'b1;
      we1_n_q     <= 1'b1;
      ce_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      clr_cnt_q   <= clr_cnt_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rdata_q     <= rdata_d;
      clr_busy_q  <= clr_busy_d;
      rsp_valid_q <= rsp_valid_d;
      latch_n_q   <= latch_n_d;
      wclk_n_q    <= wclk_n_d;
      we0_n_q     <= we0_n_d;
      we1_n_q     <= we1_n_d;
      ce_q        <= ce_d;
    end
  end

  assign ram_a       = addr_q;
  assign ram_i       = wdata_q;
  assign ram_we0_n   = we0_n_q;
  assign ram_we1_n   = we1_n_q;
  assign ram_latch_n = latch_n_q;
  assign ram_wclk_n  = wclk_n_q;
  assign ram_ce      = ce_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign clear_busy  = clr_busy_q;

endmodule

// File: tb/tb_ram82s21_ctl.sv
// Bench for ram82s21_ctl: directed vector table, random traffic against a memory model, corner sequences.
module tb_ram82s21_ctl;

  localparam int unsigned WP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [1:0] req_wdata = '0;
  logic [1:0] req_bmask = '0;
  logic       clear_start = 1'b0;
  logic       req_ready, rsp_valid, clear_busy;
  logic [1:0] rsp_rdata, ram_i, ram_d;
  logic [4:0] ram_a;
  logic       ram_we0_n, ram_we1_n, ram_latch_n, ram_wclk_n, ram_ce;

  logic [1:0] mem     [32];
  logic [1:0] ref_mem [32];
  logic       mem_init = 1'b1;
  logic       prev_wclk = 1'b1;
  int unsigned pulse_addr[$];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [1:0] wdata;
    logic [1:0] bmask;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  ram82s21_ctl #(.WR_PULSE(WP)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_bmask   (req_bmask),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .ram_a       (ram_a),
    .ram_i       (ram_i),
    .ram_we0_n   (ram_we0_n),
    .ram_we1_n   (ram_we1_n),
    .ram_latch_n (ram_latch_n),
    .ram_wclk_n  (ram_wclk_n),
    .ram_ce      (ram_ce),
    .ram_d       (ram_d)
  );

  // RAM chip model: bits commit on each clock while wclk_n and their WE_n are low;
  // outputs garbage (the complement) when not enabled.
  assign ram_d = ram_ce ? mem[ram_a] : ~mem[ram_a];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (!ram_wclk_n) begin
      if (!ram_we0_n) mem[ram_a][0] <= ram_i[0];
      if (!ram_we1_n) mem[ram_a][1] <= ram_i[1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_ce) chk("strobe_under_ce", 32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n}), 32'hf);
      if (prev_wclk && !ram_wclk_n) pulse_addr.push_back(32'(ram_a));
    end
    prev_wclk <= ram_wclk_n;
  end

  task automatic do_write(input logic [4:0] a, input logic [1:0] d, input logic [1:0] m);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_bmask = m;
    #1 chk("wr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_setup", 32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, ram_ce, req_ready, ram_a, ram_i}),
        32'({4'hf, 1'b0, 1'b0, a, d}));
    for (int k = 0; k < int'(WP); k++) begin
      @(negedge clk);
      chk("wr_pulse", 32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, ram_ce, ram_a, ram_i}),
          32'({2'b00, ~m[0], ~m[1], 1'b0, a, d}));
    end
    @(negedge clk);
    chk("wr_hold", 32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, ram_ce, req_ready, ram_a, ram_i}),
        32'({4'hf, 1'b0, 1'b0, a, d}));
    @(negedge clk);
    chk("wr_idle_ready", 32'(req_ready), 32'd1);
    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [1:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    #1 chk("rd_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_read", 32'({ram_ce, rsp_valid, ram_wclk_n, ram_a}), 32'({1'b1, 1'b0, 1'b1, a}));
    @(negedge clk);
    chk("rd_resp", 32'({ram_ce, rsp_valid, rsp_rdata}), 32'({1'b0, 1'b1, exp}));
    @(negedge clk);
    chk("rd_after", 32'({ram_ce, rsp_valid, rsp_rdata, req_ready}), 32'({1'b0, 1'b0, exp, 1'b1}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned busy_cnt;
    logic [4:0] a;

    tbl[0] = '{1'b1, 5'd5, 2'b10, 2'b11, 2'b00};
    tbl[1] = '{1'b0, 5'd5, 2'b00, 2'b00, 2'b10};
    tbl[2] = '{1'b1, 5'd7, 2'b11, 2'b01, 2'b00};
    tbl[3] = '{1'b0, 5'd7, 2'b00, 2'b00, 2'b01};
    tbl[4] = '{1'b1, 5'd7, 2'b10, 2'b10, 2'b00};
    tbl[5] = '{1'b0, 5'd7, 2'b00, 2'b00, 2'b11};
    tbl[6] = '{1'b1, 5'd5, 2'b01, 2'b00, 2'b00};
    tbl[7] = '{1'b0, 5'd5, 2'b00, 2'b00, 2'b10};
    tbl[8] = '{1'b0, 5'd6, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    #1 chk("reset_state",
           32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, ram_ce, ram_a, ram_i,
                rsp_valid, rsp_rdata, clear_busy, req_ready}),
           32'({4'hf, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0}));
    req_valid = 1'b0;
    mem_init = 1'b0;
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].wdata, tbl[i].bmask);
      else           do_read(tbl[i].addr, tbl[i].exp);
    end

    for (int i = 0; i < 80; i++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_write(a, 2'($urandom), 2'($urandom));
      else                           do_read(a, ref_mem[a]);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Back-to-back writes with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd12; req_wdata = 2'b01; req_bmask = 2'b11;
    #1 chk("b2b_first_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_addr = 5'd13; req_wdata = 2'b10;
    for (int k = 1; k < 5; k++) begin
      if (k > 1) @(negedge clk);
      chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    chk("b2b_second_ready", 32'({req_ready, ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n}), 32'h1f);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_setup", 32'({ram_latch_n, ram_wclk_n, ram_a, ram_i}), 32'({2'b11, 5'd13, 2'b10}));
    ref_mem[12] = 2'b01;
    ref_mem[13] = 2'b10;
    repeat (5) @(negedge clk);
    do_read(5'd12, 2'b01);
    do_read(5'd13, 2'b10);

    // Reset in the second PULSE cycle of a write.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 2'b11; req_bmask = 2'b11;
    #1 chk("rstp_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstp_in_pulse", 32'(ram_wclk_n), 32'd0);
    reset = 1'b1;
    #1 chk("rstp_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rstp_after",
        32'({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, ram_ce, rsp_valid, clear_busy, ram_a, ram_i}),
        32'({4'hf, 3'b000, 5'd0, 2'd0}));
    reset = 1'b0;
    #1 chk("rstp_idle_ready", 32'(req_ready), 32'd1);
    ref_mem[9] = 2'b11;
    do_write(5'd20, 2'b01, 2'b11);
    do_read(5'd20, 2'b01);

    // Reset while a read is in READ: no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd20;
    #1 chk("rstr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstr_read", 32'(ram_ce), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstr_after", 32'({ram_ce, rsp_valid, rsp_rdata}), 32'd0);
    @(negedge clk);
    chk("rstr_no_rsp", 32'({rsp_valid, req_ready}), 32'b01);

    // Whole-array clear colliding with a request; a second clear_start mid-fill.
    do_write(5'd0, 2'b11, 2'b11);
    do_write(5'd17, 2'b10, 2'b11);
    do_write(5'd31, 2'b01, 2'b11);
    @(negedge clk);
    pulse_addr.delete();
    clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 5'd3; req_wdata = 2'b11; req_bmask = 2'b11;
    #1 chk("clr_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear_start = 1'b0; req_valid = 1'b0;
    busy_cnt = 0;
    while (clear_busy && busy_cnt < 2000) begin
      busy_cnt++;
      clear_start = (busy_cnt == 10);
      @(negedge clk);
    end
    clear_start = 1'b0;
    chk("clr_busy_len", busy_cnt, 32 * (2 + WP));
    chk("clr_pulse_count", 32'(pulse_addr.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      if (i < pulse_addr.size()) chk("clr_pulse_addr", pulse_addr[i], 32'(i));
    end
    chk("clr_done_idle", 32'({clear_busy, req_ready}), 32'b01);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    do_read(5'd0, 2'b00);
    do_read(5'd17, 2'b00);
    do_read(5'd31, 2'b00);
    do_read(5'd3, 2'b00);
    repeat (4) @(negedge clk);
    chk("clr_no_restart", 32'(clear_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
